// File: rtl/pool_psum_reader.sv
// PSUM read-out sequencer for the PE array: reads every PEB, applies ReLU, requantisation
// and optional 2:1 lane max-pool, then streams the words out through a small FIFO.
module pool_psum_reader #(
  parameter int unsigned NUMPEB     = 16,
  parameter int unsigned LENPSUM    = 16,
  parameter int unsigned PSUM_WIDTH = 23,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [3:0]                       cfg_shift,
  input  logic                             cfg_pool,
  output logic [NUMPEB-1:0]                POOLPEB_EnRd,
  output logic [$clog2(LENPSUM)-1:0]       POOLPEB_AddrRd,
  input  logic [PSUM_WIDTH*LENPSUM-1:0]    PELPOOL_Dat,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*LENPSUM-1:0]    out_data,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned AddrW = $clog2(LENPSUM);
  localparam int unsigned PebW  = $clog2(NUMPEB);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WordW = DATA_WIDTH * LENPSUM;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [PebW-1:0]   peb_q;
  logic [AddrW-1:0]  addr_q;
  logic [3:0]        shift_q;
  logic              pool_q;
  logic [NUMPEB-1:0] en_rd_q;
  logic [AddrW-1:0]  addr_rd_q;
  logic              rd_vld_q;

  logic [WordW-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  logic push, pop, issue, last_addr, last_read, pipe_empty;

  logic [PSUM_WIDTH-1:0] lane_shr [LENPSUM];
  logic [DATA_WIDTH-1:0] lane_q   [LENPSUM];
  logic [WordW-1:0]      push_word;

  assign last_addr  = (addr_q == AddrW'(LENPSUM - 1));
  assign last_read  = last_addr && (peb_q == PebW'(NUMPEB - 1));
  assign push       = rd_vld_q;
  assign pop        = out_valid && out_ready;
  assign pipe_empty = (en_rd_q == '0) && !rd_vld_q && (count_q == '0);

  assign POOLPEB_EnRd   = en_rd_q;
  assign POOLPEB_AddrRd = addr_rd_q;
  assign out_valid      = (count_q != '0);
  assign out_data       = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  if (issue && last_read) state_d = StDrain;
      StDrain: if (pipe_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; the occupancy test counts the read already on the bus as the single in-flight word
  always_comb begin
    busy  = (state_q == StRead) || (state_q == StDrain);
    done  = (state_q == StDone);
    issue = (state_q == StRead) &&
            ((count_d + CntW'(en_rd_q != '0)) < CntW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peb_q     <= '0;
      addr_q    <= '0;
      shift_q   <= '0;
      pool_q    <= 1'b0;
      en_rd_q   <= '0;
      addr_rd_q <= '0;
      rd_vld_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        shift_q <= cfg_shift;
        pool_q  <= cfg_pool;
        peb_q   <= '0;
        addr_q  <= '0;
      end else if (issue) begin
        addr_q <= last_addr ? '0 : addr_q + 1'b1;
        if (last_addr) peb_q <= peb_q + 1'b1;
      end
      en_rd_q  <= issue ? ({{(NUMPEB-1){1'b0}}, 1'b1} << peb_q) : '0;
      if (issue) addr_rd_q <= addr_q;
      rd_vld_q <= (en_rd_q != '0);
      if (push) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // ReLU, shift and saturate each lane
  always_comb begin
    for (int i = 0; i < LENPSUM; i++) begin
      lane_shr[i] = PELPOOL_Dat[i*PSUM_WIDTH +: PSUM_WIDTH] >> shift_q;
      if (PELPOOL_Dat[i*PSUM_WIDTH + PSUM_WIDTH - 1]) begin
        lane_q[i] = '0;
      end else if (|lane_shr[i][PSUM_WIDTH-1:DATA_WIDTH]) begin
        lane_q[i] = '1;
      end else begin
        lane_q[i] = lane_shr[i][DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    push_word = '0;
    if (pool_q) begin
      for (int j = 0; j < LENPSUM / 2; j++) begin
        push_word[j*DATA_WIDTH +: DATA_WIDTH] =
            (lane_q[2*j] > lane_q[2*j+1]) ? lane_q[2*j] : lane_q[2*j+1];
      end
    end else begin
      for (int j = 0; j < LENPSUM; j++) begin
        push_word[j*DATA_WIDTH +: DATA_WIDTH] = lane_q[j];
      end
    end
  end

endmodule

// File: tb/tb_pool_psum_reader.sv
// Bench for pool_psum_reader: PEB read-port model plus a scoreboard of expected output words.
module tb_pool_psum_reader;

  localparam int NPEB = 16;
  localparam int LEN  = 16;
  localparam int PW   = 23;
  localparam int DW   = 8;
  localparam int OW   = DW * LEN;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [3:0]           cfg_shift;
  logic                 cfg_pool;
  logic [NPEB-1:0]      POOLPEB_EnRd;
  logic [3:0]           POOLPEB_AddrRd;
  logic [PW*LEN-1:0]    PELPOOL_Dat;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        out_data;
  logic                 busy;
  logic                 done;

  pool_psum_reader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_shift      (cfg_shift),
    .cfg_pool       (cfg_pool),
    .POOLPEB_EnRd   (POOLPEB_EnRd),
    .POOLPEB_AddrRd (POOLPEB_AddrRd),
    .PELPOOL_Dat    (PELPOOL_Dat),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int pat_cur = 0, shift_cur = 0;
  bit pool_cur = 0;
  int exp_peb = 0, exp_addr = 0, n_reads = 0, n_done = 0;
  int ready_mode = 0;
  logic [NPEB-1:0] rd_en_s = '0;
  logic [3:0]      rd_addr_s = '0;
  logic [OW-1:0]   sb[$];

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lane_val(int pat, int peb, int addr, int i);
    case (pat)
      0: return 1000;
      1: case (i % 4) 0: return -5; 1: return 1100; 2: return 0; default: return 255; endcase
      2: case (i % 4) 0: return 10; 1: return 200; 2: return 600; default: return 3; endcase
      default: return ((peb * 37 + addr * 11 + i * 5 + 1) * 7919) % 400000 - 100000;
    endcase
  endfunction

  function automatic logic [OW-1:0] exp_word(int pat, int peb, int addr, int shift, bit pool);
    logic [OW-1:0] w;
    int q[LEN];
    int t4[4];
    int v, s;
    w = '0;
    case (pat)
      0: for (int i = 0; i < LEN; i++) w[i*DW +: DW] = 8'hFA;
      1: begin
        t4 = '{0, 255, 0, 63};
        for (int i = 0; i < LEN; i++) w[i*DW +: DW] = 8'(t4[i % 4]);
      end
      2: for (int j = 0; j < LEN / 2; j++) w[j*DW +: DW] = (j % 2 == 0) ? 8'd100 : 8'd255;
      default: begin
        for (int i = 0; i < LEN; i++) begin
          v = lane_val(pat, peb, addr, i);
          if (v < 0) q[i] = 0;
          else begin
            s = v >>> shift;
            q[i] = (s > 255) ? 255 : s;
          end
        end
        if (pool) begin
          for (int j = 0; j < LEN / 2; j++)
            w[j*DW +: DW] = 8'((q[2*j] > q[2*j+1]) ? q[2*j] : q[2*j+1]);
        end else begin
          for (int i = 0; i < LEN; i++) w[i*DW +: DW] = 8'(q[i]);
        end
      end
    endcase
    return w;
  endfunction

  // PEB model: answers the read seen on the bus during the following cycle
  always @(posedge clk) begin
    int peb;
    #1;
    if (rd_en_s != '0) begin
      peb = 0;
      for (int k = NPEB - 1; k >= 0; k--) if (rd_en_s[k]) peb = k;
      for (int i = 0; i < LEN; i++) PELPOOL_Dat[i*PW +: PW] = PW'(lane_val(pat_cur, peb, int'(rd_addr_s), i));
    end else begin
      PELPOOL_Dat = {LEN{23'h012345}};
    end
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: read order, scoreboard push on read, compare on accepted output
  always @(negedge clk) begin
    rd_en_s   = POOLPEB_EnRd;
    rd_addr_s = POOLPEB_AddrRd;
    if (!rst) begin
      if (POOLPEB_EnRd != '0) begin
        chk("rd_en_order", POOLPEB_EnRd, 16'(1) << exp_peb);
        chk("rd_addr_order", POOLPEB_AddrRd, exp_addr);
        sb.push_back(exp_word(pat_cur, exp_peb, exp_addr, shift_cur, pool_cur));
        n_reads++;
        if (exp_addr == LEN - 1) begin
          exp_addr = 0;
          exp_peb++;
        end else begin
          exp_addr++;
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_has_entry", sb.size(), 1);
        else chk("out_data", out_data, sb.pop_front());
      end
      if (done) n_done++;
    end
  end

  // mode: 0 ready high, 1 ready held low then random, 2 random ready + stray starts, 3 abort
  task automatic run_pass(input int pat, input int shift, input bit pool, input int mode);
    bit fin;
    pat_cur = pat; shift_cur = shift; pool_cur = pool;
    exp_peb = 0; exp_addr = 0; n_reads = 0; n_done = 0;
    sb.delete();
    ready_mode = (mode == 1) ? 1 : (mode == 2) ? 2 : 0;
    cfg_shift = 4'(shift);
    cfg_pool  = pool;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_shift = ~cfg_shift;
    cfg_pool  = ~pool;
    chk("busy_after_start", busy, 1);
    fin = 0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      start = (mode == 2 && (cyc == 10 || cyc == 100));
      if (mode == 1 && cyc == 30) begin
        chk("stall_reads", n_reads, 4);
        chk("stall_en_idle", POOLPEB_EnRd, 0);
        ready_mode = 2;
      end
      if (mode == 3 && POOLPEB_EnRd == 16'h0008 && POOLPEB_AddrRd == 4'd7) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_en", POOLPEB_EnRd, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        sb.delete();
        fin = 1;
      end else if (done) begin
        fin = 1;
        chk("done_fifo_empty", out_valid, 0);
        chk("busy_at_done", busy, 0);
        chk("reads_per_pass", n_reads, 256);
        chk("sb_drained", sb.size(), 0);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("busy_after_done", busy, 0);
        repeat (3) @(negedge clk);
        chk("done_count", n_done, 1);
      end
    end
    start = 1'b0;
    if (!fin) chk("pass_finished", fin, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_shift = '0; cfg_pool = 1'b0; out_ready = 1'b1;
    PELPOOL_Dat = '0;
    repeat (3) @(negedge clk);
    chk("rst_en", POOLPEB_EnRd, 0);
    chk("rst_addr", POOLPEB_AddrRd, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_pass(0, 2, 1'b0, 0);
    run_pass(1, 2, 1'b0, 0);
    run_pass(2, 1, 1'b1, 0);
    run_pass(3, 9, 1'b0, 1);
    run_pass(0, 2, 1'b0, 3);
    run_pass(1, 2, 1'b0, 0);
    run_pass(3, 7, 1'b1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
